mult_booth: RTL and testbench

- Sequential signed 32x32 multiplier for the MIPS-style datapath; the multiply counterpart of the HI/LO divide unit.
- Uses radix-2 Booth's algorithm, one iteration per clock.
- Writes a 64-bit signed product to HI (upper word) and LO (lower word) for mfhi/mflo.
- Driven by the main control FSM with a start pulse; reports busy and a one-cycle done.

---
 rtl/mult_booth.sv | 149 ++++++++++++++
 tb/tb_mult_booth.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_booth.sv
// -----------------------------------------------------------------------------
// mult_booth
// Sequential signed WIDTH x WIDTH multiplier using radix-2 Booth recoding,
// one iteration per clock. Produces a 2*WIDTH-bit signed product split into
// HI (upper word) and LO (lower word) registers for mfhi/mflo.
//
// Ports:
//   clock  - system clock, rising-edge active
//   reset  - asynchronous, active-low reset
//   start  - request a multiply; only honoured while idle
//   A      - multiplicand, signed two's complement
//   B      - multiplier, signed two's complement
//   hi     - upper word of the last completed product (registered)
//   lo     - lower word of the last completed product (registered)
//   busy   - high whenever a multiply is in progress or completing
//   done   - one-cycle pulse when hi/lo have just been updated
// -----------------------------------------------------------------------------
module mult_booth #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic signed [WIDTH:0]   m_q, m_d;
   logic signed [WIDTH:0]   acc_q, acc_d;
   logic        [WIDTH-1:0] q_q, q_d;
   logic                    q1_q, q1_d;
   logic        [CNT_W-1:0] cnt_q, cnt_d;
   logic        [WIDTH-1:0] hi_q, hi_d;
   logic        [WIDTH-1:0] lo_q, lo_d;
   logic                    done_q, done_d;

   logic signed [WIDTH:0]   acc_sum;
   logic      [2*WIDTH+1:0] shifted;

   // Booth recoding of the pair {Q[0], q_1}: 01 adds M, 10 subtracts M.
   // ACC carries one guard bit so that subtracting M = -2^(WIDTH-1) fits.
   function automatic logic signed [WIDTH:0] booth_add(
      input logic signed [WIDTH:0] acc,
      input logic signed [WIDTH:0] m,
      input logic [1:0]            pair
   );
      case (pair)
         2'b01:   booth_add = acc + m;
         2'b10:   booth_add = acc - m;
         default: booth_add = acc;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      q1_d    = q1_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      acc_sum = acc_q;
      shifted = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               m_d     = {A[WIDTH-1], A};
               acc_d   = '0;
               q_d     = B;
               q1_d    = 1'b0;
               cnt_d   = '0;
               state_d = ST_CALC;
            end
         end

         ST_CALC: begin
            acc_sum = booth_add(acc_q, m_q, {q_q[0], q1_q});
            // Arithmetic right shift of {ACC, Q, q_1}: the old q_1 falls off,
            // Q[0] becomes the new q_1 and the ACC sign bit is replicated.
            shifted = {acc_sum[WIDTH], acc_sum, q_q};
            acc_d   = shifted[2*WIDTH+1:WIDTH+1];
            q_d     = shifted[WIDTH:1];
            q1_d    = shifted[0];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               hi_d    = acc_d[WIDTH-1:0];
               lo_d    = q_d;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign done = done_q;
   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mult_booth.sv
// -----------------------------------------------------------------------------
// tb_mult_booth
// Self-checking bench for mult_booth. A cycle-level behavioural model (phase
// counter plus a plain 64-bit signed multiply) predicts hi/lo/busy/done and is
// compared against the DUT on every falling edge; directed tasks add literal
// expectations for latency, corner products, ignored starts, mid-operation
// reset and back-to-back operation.
// -----------------------------------------------------------------------------
module tb_mult_booth;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   bit en     = 1'b0;

   mult_booth #(.WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .A     (A),
      .B     (B),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_phase = 0 when idle, otherwise (edges since the accepting edge) + 1.
   int               m_phase   = 0;
   logic signed [63:0] m_op    = '0;
   logic [31:0]      m_hi      = '0;
   logic [31:0]      m_lo      = '0;
   logic             m_done    = 1'b0;
   int               m_accepts = 0;
   int               dut_dones = 0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_phase <= 0;
         m_hi    <= '0;
         m_lo    <= '0;
         m_done  <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_phase == 0) begin
            if (start) begin
               m_phase   <= 1;
               m_op      <= $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
               m_accepts <= m_accepts + 1;
            end
         end else if (m_phase == 32) begin
            m_phase <= 33;
            m_hi    <= m_op[63:32];
            m_lo    <= m_op[31:0];
            m_done  <= 1'b1;
         end else if (m_phase == 33) begin
            m_phase <= 0;
         end else begin
            m_phase <= m_phase + 1;
         end
      end
   end

   always @(negedge clock) begin
      if (en) begin
         chk("cyc_hi",   {32'h0, hi}, {32'h0, m_hi});
         chk("cyc_lo",   {32'h0, lo}, {32'h0, m_lo});
         chk("cyc_busy", {63'h0, busy}, {63'h0, (m_phase != 0)});
         chk("cyc_done", {63'h0, done}, {63'h0, m_done});
         if (done) dut_dones++;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock); #1;
      A = a;
      B = b;
      start = 1'b1;
   endtask

   task automatic wait_done(input int limit, input bit keep, output int n, output bit seen);
      n = 0;
      seen = 1'b0;
      while (!seen && n < limit) begin
         @(negedge clock); #1;
         if (!keep) start = 1'b0;
         n++;
         if (done) seen = 1'b1;
      end
   endtask

   task automatic mul_check(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el,
                            input string tag);
      int n;
      bit seen;
      launch(a, b);
      wait_done(40, 1'b0, n, seen);
      chk({tag, "_done_seen"}, {63'h0, seen}, 64'h1);
      chk({tag, "_latency"}, 64'(n), 64'd33);
      chk({tag, "_hi"}, {32'h0, hi}, {32'h0, eh});
      chk({tag, "_lo"}, {32'h0, lo}, {32'h0, el});
      @(negedge clock); #1;
      chk({tag, "_idle"}, {63'h0, busy}, 64'h0);
   endtask

   initial begin
      int n, n2;
      bit seen, seen2;
      logic [31:0] ra, rb;
      logic signed [63:0] rp;

      #1 reset = 1'b0;
      repeat (2) @(negedge clock);
      #1 reset = 1'b1;
      chk("rst_hi",   {32'h0, hi}, 64'h0);
      chk("rst_lo",   {32'h0, lo}, 64'h0);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_done", {63'h0, done}, 64'h0);
      en = 1'b1;

      mul_check(32'd7,        32'd3,        32'h00000000, 32'h00000015, "m7x3");
      mul_check(32'hFFFFFFFB, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFF1, "mneg5x3");
      mul_check(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mneg1sq");
      mul_check(32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mminsq");
      mul_check(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, "mmaxsq");
      mul_check(32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000, "mminxmax");
      mul_check(32'd0,        32'h80000000, 32'h00000000, 32'h00000000, "mzero");

      // Operand change and start pulse while busy must be ignored.
      launch(32'd7, 32'd3);
      repeat (10) begin @(negedge clock); #1; start = 1'b0; end
      A = 32'd100; B = 32'd100; start = 1'b1;
      @(negedge clock); #1; start = 1'b0;
      wait_done(40, 1'b0, n, seen);
      chk("ign_done_seen", {63'h0, seen}, 64'h1);
      chk("ign_latency", 64'(n), 64'd22);
      chk("ign_lo", {32'h0, lo}, 64'h15);
      @(negedge clock); #1;
      chk("ign_busy_drop", {63'h0, busy}, 64'h0);
      repeat (40) begin
         @(negedge clock); #1;
         chk("ign_no_second_done", {63'h0, done}, 64'h0);
      end

      // Reset in the middle of 2*2 after a completed 7*3.
      mul_check(32'd7, 32'd3, 32'h0, 32'h15, "pre_rst");
      launch(32'd2, 32'd2);
      repeat (15) begin @(negedge clock); #1; start = 1'b0; end
      reset = 1'b0;
      #1;
      chk("abort_hi",   {32'h0, hi}, 64'h0);
      chk("abort_lo",   {32'h0, lo}, 64'h0);
      chk("abort_busy", {63'h0, busy}, 64'h0);
      chk("abort_done", {63'h0, done}, 64'h0);
      repeat (2) @(negedge clock);
      #1 reset = 1'b1;
      repeat (36) begin
         @(negedge clock); #1;
         chk("abort_no_done", {63'h0, done}, 64'h0);
      end
      mul_check(32'd2, 32'd2, 32'h0, 32'h4, "post_rst");

      // start held high: back-to-back period of 34 cycles.
      launch(32'd3, 32'd5);
      wait_done(40, 1'b1, n, seen);
      wait_done(40, 1'b1, n2, seen2);
      start = 1'b0;
      chk("b2b_first_seen", {63'h0, seen}, 64'h1);
      chk("b2b_first_lat", 64'(n), 64'd33);
      chk("b2b_second_seen", {63'h0, seen2}, 64'h1);
      chk("b2b_period", 64'(n2), 64'd34);
      chk("b2b_lo", {32'h0, lo}, 64'd15);
      @(negedge clock); #1;
      chk("b2b_idle", {63'h0, busy}, 64'h0);

      // Random signed operands against a direct 64-bit signed product.
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 50 == 0) ra = 32'h80000000;
         if (i % 70 == 0) rb = 32'h80000000;
         rp = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
         mul_check(ra, rb, rp[63:32], rp[31:0], "rnd");
      end

      repeat (3) @(negedge clock);
      #1;
      chk("done_count", 64'(dut_dones), 64'(m_accepts) - 64'd1);
      en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // The aborted 2*2 is counted as accepted by the model but never completes,
   // hence the "- 1" in the final done-count comparison.

endmodule
